fp32_dual_rail_injector: RTL and testbench

- Synchronous-to-asynchronous entry stage of the square-root datapath.
- Accepts an FP32 operand on a clocked valid/ready interface, classifies it, and drives normal operands as a dual-rail fp_components_t codeword into the FP fork.
- Runs the fork's 4-phase return-to-zero handshake on the fork's single combined acknowledge.
- Special operands bypass the asynchronous pipe and return a class code directly on the clocked side.

---
 rtl/fp32_dual_rail_injector.sv | 169 ++++++++++++++++
 tb/tb_fp32_dual_rail_injector.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_dual_rail_injector.sv
// Clocked entry stage of the square-root datapath: classifies FP32 operands, injects
// normal ones into the FP fork as dual-rail codewords and returns specials directly.
package pa_AsyncCordic;
  parameter int EW = 7;
  parameter int FW = 22;

  typedef struct packed {
    logic t;
    logic f;
  } dual_rail_t;

  typedef struct packed {
    dual_rail_t [EW:0] exp;
    dual_rail_t [FW:0] fraction;
  } fp_components_t;
endpackage

module fp32_dual_rail_injector #(
  parameter int EW          = pa_AsyncCordic::EW,
  parameter int FW          = pa_AsyncCordic::FW,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic                           clk,
  input  logic                           arst,
  input  logic                           in_valid,
  input  logic [EW+FW+2:0]               in_data,
  output logic                           in_ready,
  output pa_AsyncCordic::fp_components_t fp32,
  input  logic                           fork_ack,
  output logic                           bypass_valid,
  output logic [1:0]                     bypass_class,
  output logic                           busy,
  output logic                           timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RTZ  = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  pa_AsyncCordic::fp_components_t rails_q, rails_d;
  logic [SYNC_STAGES-1:0]         ack_sync_q, ack_sync_d;
  logic [SYNC_STAGES-1:0]         init_q, init_d;
  logic                           in_ready_q, in_ready_d;
  logic                           bypass_valid_q, bypass_valid_d;
  logic [1:0]                     bypass_class_q, bypass_class_d;
  logic                           busy_q, busy_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic                           timeout_q, timeout_d;
  logic                           ack_s;
  logic                           accept;
  logic [2:0]                     cls;

  // Returns {special, class}; class is 00 zero, 01 +Inf, 10 NaN, 11 negative non-zero.
  function automatic logic [2:0] classify(input logic [EW+FW+2:0] w);
    logic          sgn;
    logic [EW:0]   e;
    logic [FW:0]   fr;
    logic [2:0]    r;
    sgn = w[EW+FW+2];
    e   = w[EW+FW+1:FW+1];
    fr  = w[FW:0];
    if ((&e) && (|fr))                  r = 3'b110;
    else if (&e)                        r = sgn ? 3'b111 : 3'b101;
    else if ((e == '0) && (fr == '0))   r = 3'b100;
    else if (sgn)                       r = 3'b111;
    else                                r = 3'b000;
    return r;
  endfunction

  function automatic pa_AsyncCordic::fp_components_t encode(input logic [EW+FW+2:0] w);
    pa_AsyncCordic::fp_components_t c;
    c = '0;
    for (int i = 0; i <= EW; i++) c.exp[i] = '{t: w[FW+1+i], f: ~w[FW+1+i]};
    for (int i = 0; i <= FW; i++) c.fraction[i] = '{t: w[i], f: ~w[i]};
    return c;
  endfunction

  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d        = state_q;
    rails_d        = rails_q;
    in_ready_d     = 1'b0;
    bypass_valid_d = 1'b0;
    bypass_class_d = bypass_class_q;
    ack_sync_d     = {ack_sync_q[SYNC_STAGES-2:0], fork_ack};
    // in_ready waits until the synchronizer holds real ack samples after reset
    init_d         = {init_q[SYNC_STAGES-2:0], 1'b1};
    accept         = in_valid && in_ready_q;
    cls            = classify(in_data);
    case (state_q)
      IDLE: begin
        if (accept && cls[2]) begin
          bypass_valid_d = 1'b1;
          bypass_class_d = cls[1:0];
        end else if (accept) begin
          rails_d = encode(in_data);
          state_d = DATA;
        end else begin
          state_d = IDLE;
        end
        in_ready_d = init_q[SYNC_STAGES-1] && !ack_s && (state_d == IDLE);
      end
      DATA: begin
        if (ack_s) begin
          rails_d = '0;
          state_d = RTZ;
        end else begin
          state_d = DATA;
        end
      end
      RTZ: begin
        if (!ack_s) state_d = IDLE;
        else        state_d = RTZ;
      end
      default: begin
        rails_d = '0;
        state_d = IDLE;
      end
    endcase
    if (state_d != state_q)                          cnt_d = '0;
    else if ((state_q != IDLE) && (cnt_q != TIMEOUT_C)) cnt_d = cnt_q + 1'b1;
    else                                             cnt_d = cnt_q;
    timeout_d = timeout_q || (cnt_d == TIMEOUT_C);
    busy_d    = (state_d != IDLE);
  end

  // Handshake state, rail flops, synchronizer and clocked-side outputs.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q        <= IDLE;
      rails_q        <= '0;
      ack_sync_q     <= '0;
      init_q         <= '0;
      in_ready_q     <= 1'b0;
      bypass_valid_q <= 1'b0;
      bypass_class_q <= 2'b00;
      busy_q         <= 1'b0;
      cnt_q          <= '0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      rails_q        <= rails_d;
      ack_sync_q     <= ack_sync_d;
      init_q         <= init_d;
      in_ready_q     <= in_ready_d;
      bypass_valid_q <= bypass_valid_d;
      bypass_class_q <= bypass_class_d;
      busy_q         <= busy_d;
      cnt_q          <= cnt_d;
      timeout_q      <= timeout_d;
    end
  end

  assign fp32         = rails_q;
  assign in_ready     = in_ready_q;
  assign bypass_valid = bypass_valid_q;
  assign bypass_class = bypass_class_q;
  assign busy         = busy_q;
  assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_fp32_dual_rail_injector.sv
// Directed and table-driven bench for fp32_dual_rail_injector with a 4-phase ack
// responder and a codeword scoreboard watching the dual-rail outputs.
module tb_fp32_dual_rail_injector;
  localparam int SYNC = 2;
  localparam int TO   = 1024;

  logic clk, arst, in_valid, in_ready, fork_ack, bypass_valid, busy, timeout_err;
  logic [31:0] in_data;
  logic [1:0]  bypass_class;
  pa_AsyncCordic::fp_components_t fp32;

  logic ack_auto = 1'b0, ack_man = 1'b0, ack_a = 1'b0, rand_dly = 1'b0;
  int   ack_dly = 0, acnt = 0;
  int   total = 0, bad = 0, illegal_cnt = 0, nospc_cnt = 0;
  logic [30:0] seen_q[$];
  logic [30:0] exp_q[$];

  typedef struct {
    logic [31:0] d;
    logic        special;
    logic [1:0]  cls;
    logic [30:0] cw;
  } vec_t;
  vec_t tbl[15];
  logic [31:0] sp_d[4];
  logic [1:0]  sp_c[4];

  assign fork_ack = ack_auto ? ack_a : ack_man;

  fp32_dual_rail_injector #(.EW(7), .FW(22), .SYNC_STAGES(SYNC), .TIMEOUT(TO)) dut (
    .clk(clk), .arst(arst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .fp32(fp32), .fork_ack(fork_ack), .bypass_valid(bypass_valid),
    .bypass_class(bypass_class), .busy(busy), .timeout_err(timeout_err));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [30:0] cw_val(input pa_AsyncCordic::fp_components_t c);
    logic [30:0] v;
    for (int i = 0; i < 8; i++)  v[23+i] = c.exp[i].t;
    for (int i = 0; i < 23; i++) v[i]    = c.fraction[i].t;
    return v;
  endfunction

  function automatic bit cw_complete(input pa_AsyncCordic::fp_components_t c);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++)  if (c.exp[i].t == c.exp[i].f) ok = 1'b0;
    for (int i = 0; i < 23; i++) if (c.fraction[i].t == c.fraction[i].f) ok = 1'b0;
    return ok;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Fork model: acks a complete codeword, releases after spacer, optional random delay.
  initial begin
    forever begin
      @(negedge clk);
      if (!ack_auto) begin
        ack_a = 1'b0;
        acnt  = 0;
      end else if ((!ack_a && cw_complete(fp32)) || (ack_a && fp32 == '0)) begin
        if (acnt >= ack_dly) begin
          ack_a   = ~ack_a;
          acnt    = 0;
          ack_dly = rand_dly ? int'($urandom_range(0, 20)) : 0;
        end else begin
          acnt++;
        end
      end else begin
        acnt = 0;
      end
    end
  end

  initial begin
    logic        prev_full;
    logic [30:0] pv;
    prev_full = 1'b0;
    pv = '0;
    forever begin
      @(negedge clk);
      if (fp32 != '0 && !cw_complete(fp32)) begin
        illegal_cnt++;
      end else if (cw_complete(fp32)) begin
        if (!prev_full) seen_q.push_back(cw_val(fp32));
        else if (cw_val(fp32) != pv) nospc_cnt++;
        prev_full = 1'b1;
        pv = cw_val(fp32);
      end else begin
        prev_full = 1'b0;
      end
    end
  end

  task automatic send(input logic [31:0] d, input bit normal, output int waits);
    in_valid = 1'b1;
    in_data  = d;
    waits    = 0;
    while (!in_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    check("accept", 64'(in_ready), 64'd1);
    if (in_ready) begin
      @(posedge clk);
      if (normal) exp_q.push_back(d[30:0]);
      @(negedge clk);
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(in_ready && !busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 64'(in_ready && !busy), 64'd1);
  endtask

  task automatic wait_spacer();
    int n;
    n = 0;
    while (fp32 != '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("spacer_reached", 64'(fp32 == '0), 64'd1);
  endtask

  function automatic logic [30:0] sb_at(input int i);
    return (seen_q.size() > i) ? seen_q[i] : 31'h7FFFFFFF;
  endfunction

  initial begin
    int w, n, mism;
    logic [31:0] d;
    tbl[0]  = '{32'h3F800000, 1'b0, 2'b00, {8'h7F, 23'h000000}};
    tbl[1]  = '{32'h40800000, 1'b0, 2'b00, {8'h81, 23'h000000}};
    tbl[2]  = '{32'h41100000, 1'b0, 2'b00, {8'h82, 23'h100000}};
    tbl[3]  = '{32'h40000000, 1'b0, 2'b00, {8'h80, 23'h000000}};
    tbl[4]  = '{32'h00000001, 1'b0, 2'b00, {8'h00, 23'h000001}};
    tbl[5]  = '{32'h007FFFFF, 1'b0, 2'b00, {8'h00, 23'h7FFFFF}};
    tbl[6]  = '{32'h7F7FFFFF, 1'b0, 2'b00, {8'hFE, 23'h7FFFFF}};
    tbl[7]  = '{32'hC0000000, 1'b1, 2'b11, 31'h0};
    tbl[8]  = '{32'h7F800000, 1'b1, 2'b01, 31'h0};
    tbl[9]  = '{32'h7FC00000, 1'b1, 2'b10, 31'h0};
    tbl[10] = '{32'h80000000, 1'b1, 2'b00, 31'h0};
    tbl[11] = '{32'h00000000, 1'b1, 2'b00, 31'h0};
    tbl[12] = '{32'hFF800000, 1'b1, 2'b11, 31'h0};
    tbl[13] = '{32'hFFC00001, 1'b1, 2'b10, 31'h0};
    tbl[14] = '{32'h80000001, 1'b1, 2'b11, 31'h0};
    sp_d = '{32'hC0000000, 32'h7F800000, 32'h7FC00000, 32'h80000000};
    sp_c = '{2'b11, 2'b01, 2'b10, 2'b00};

    arst = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_bypass_valid", 64'(bypass_valid), 64'd0);
    check("rst_bypass_class", 64'(bypass_class), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_timeout", 64'(timeout_err), 64'd0);
    check("rst_spacer", 64'(fp32 == '0), 64'd1);
    arst = 1'b1;

    // 1.0 with hand-driven ack: codeword, then both handshake latencies
    send(32'h3F800000, 1'b1, w);
    in_valid = 1'b0;
    check("one_cw", 64'(cw_val(fp32)), 64'({8'h7F, 23'h0}));
    check("one_complete", 64'(cw_complete(fp32)), 64'd1);
    check("one_busy", 64'(busy), 64'd1);
    ack_man = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (fp32 != '0 && n < 20);
    check("ack_rise_to_spacer", 64'(n), 64'(SYNC + 1));
    check("rtz_busy", 64'(busy), 64'd1);
    check("rtz_not_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    ack_man = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!in_ready && n < 20);
    check("ack_fall_to_ready", 64'(n), 64'(SYNC + 2));
    @(negedge clk);

    ack_auto = 1'b1;
    for (int i = 0; i < 15; i++) begin
      send(tbl[i].d, !tbl[i].special, w);
      in_valid = 1'b0;
      if (tbl[i].special) begin
        check("tbl_bypass_valid", 64'(bypass_valid), 64'd1);
        check("tbl_bypass_class", 64'(bypass_class), 64'(tbl[i].cls));
        check("tbl_bypass_spacer", 64'(fp32 == '0), 64'd1);
      end else begin
        check("tbl_cw", 64'(cw_val(fp32)), 64'(tbl[i].cw));
        check("tbl_busy", 64'(busy), 64'd1);
        check("tbl_no_bypass", 64'(bypass_valid), 64'd0);
      end
    end
    wait_idle();

    seen_q.delete(); exp_q.delete();
    send(32'h40800000, 1'b1, w);
    send(32'h41100000, 1'b1, w);
    in_valid = 1'b0;
    wait_idle();
    check("b2b_count", 64'(seen_q.size()), 64'd2);
    check("b2b_cw0", 64'(sb_at(0)), 64'({8'h81, 23'h000000}));
    check("b2b_cw1", 64'(sb_at(1)), 64'({8'h82, 23'h100000}));

    seen_q.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      send(sp_d[i], 1'b0, w);
      if (i > 0) check("bp_back_to_back", 64'(w), 64'd0);
      check("bp_valid", 64'(bypass_valid), 64'd1);
      check("bp_class", 64'(bypass_class), 64'(sp_c[i]));
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_pulse_end", 64'(bypass_valid), 64'd0);
    check("bp_no_codeword", 64'(seen_q.size()), 64'd0);

    ack_auto = 1'b0; ack_man = 1'b0;
    send(32'h40000000, 1'b1, w);
    in_valid = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!timeout_err && n < TO + 10);
    check("timeout_cycles", 64'(n), 64'(TO));
    check("timeout_still_data", 64'(cw_val(fp32)), 64'({8'h80, 23'h0}));
    @(negedge clk);
    ack_man = 1'b1;
    wait_spacer();
    ack_man = 1'b0;
    wait_idle();
    check("timeout_sticky", 64'(timeout_err), 64'd1);

    send(32'h3F800000, 1'b1, w);
    in_valid = 1'b0;
    ack_man = 1'b1;
    arst = 1'b0;
    #1;
    check("mid_rst_spacer", 64'(fp32 == '0), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_timeout_clr", 64'(timeout_err), 64'd0);
    @(negedge clk);
    arst = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready || bypass_valid) n++;
    end
    check("stale_ack_blocks", 64'(n), 64'd0);
    ack_man = 1'b0;
    seen_q.delete(); exp_q.delete();
    send(32'h3F800000, 1'b1, w);
    in_valid = 1'b0;
    check("post_rst_cw", 64'(cw_val(fp32)), 64'({8'h7F, 23'h0}));
    ack_man = 1'b1;
    wait_spacer();
    ack_man = 1'b0;
    wait_idle();

    seen_q.delete(); exp_q.delete();
    ack_auto = 1'b1; rand_dly = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        send(sp_d[$urandom_range(0, 3)], 1'b0, w);
      end else begin
        d = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
        send(d, 1'b1, w);
      end
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    wait_idle();
    check("rand_count", 64'(seen_q.size()), 64'(exp_q.size()));
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++) if (sb_at(i) !== exp_q[i]) mism++;
    check("rand_order", 64'(mism), 64'd0);

    check("rails_legal", 64'(illegal_cnt), 64'd0);
    check("spacer_between", 64'(nospc_cnt), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
